ram_dma: RTL and testbench
==========================

# ram_dma

Word-level memory initiator that drives the 1024 x 20-bit `ram` port (`addr`, `write`, `str`, `ld`, `read`) on behalf of the CPU or debug logic. Given a start pulse and a descriptor, it performs one of three bulk operations:

- copy a block;
- fill a block with a constant;
- compute a wrapping 20-bit checksum of a block.

It sits between the control unit and `ram`, and owns the RAM port while busy.

## Interface
Parameters:
- `AW`, 10, RAM address width (1024 words)
- `DW`, 20, RAM data width

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: request; sampled only in IDLE
- `mode` in 2: 0 copy, 1 fill, 2 checksum, 3 reserved
- `src_addr` in AW: first source word (copy, checksum)
- `dst_addr` in AW: first destination word (copy, fill)
- `len` in AW+1: word count, 0..1024
- `fill_data` in DW: fill constant
- `busy` out 1: operation in progress
- `done` out 1: one-cycle completion pulse
- `err` out 1: pulses with `done` for a reserved mode
- `result` out DW: checksum, held until next checksum start
- `mem_addr` out AW: to `ram` addr
- `mem_write` out DW: to `ram` write
- `mem_str` out 1: to `ram` str
- `mem_ld` out 1: to `ram` ld
- `mem_read` in DW: from `ram` read; valid in the cycle after a cycle with `mem_ld=1`

## Operation
- States: IDLE, COPY_RD, COPY_WR, FILL, SUM_RD, SUM_DRAIN, DONE.
- Reset values: state IDLE; `busy`, `done`, `err`, `mem_str`, `mem_ld` all 0; `mem_addr` 0; `result` 0; internal counters 0. Reset mid-operation aborts immediately. RAM contents already written stay written.
- In IDLE, `start=1` latches `mode`, `src_addr`, `dst_addr`, `len`, `fill_data`. `start` while busy is ignored.
- `len=0` or `mode=3`: go straight to DONE with no RAM access. `err=1` for mode 3 only.
- Copy: COPY_RD (ld, addr=src+i) then COPY_WR (str, addr=dst+i, write=`mem_read`). Loop until i=len-1, then DONE.
- Fill: FILL asserts str each cycle (addr=dst+i, write=fill reg) for len cycles, then DONE.
- Checksum: SUM_RD asserts ld each cycle (addr=src+i) for len cycles, then one SUM_DRAIN cycle. The accumulator adds `mem_read` in every cycle following an ld. Then DONE; `result` updates on entry to DONE.
- DONE lasts one cycle with `done=1`, then IDLE.
- Address arithmetic is modulo 2^AW: block access wraps from 1023 to 0. The checksum sum wraps modulo 2^DW.
- Copy runs in ascending order only. Overlap with dst in (src, src+len) replicates the first dst-src words. This is defined behaviour, not an error.
- `mem_str` and `mem_ld` are never both 1.
- `mem_write` is combinational: `mem_read` in COPY_WR, the fill register in FILL, otherwise 0.

## Timing
- Start is sampled at edge E0. `busy` rises at E0 and falls at the edge that leaves DONE.
- `mem_addr`, `mem_str`, `mem_ld`, `busy`, `done`, `err` are registered.
- Copy of N words: reads at E0, E2, …; writes at E1, E3, …; `done` high in the cycle after E2N.
- Fill of N words: stores at E0..E(N-1); `done` high after EN.
- Checksum of N words: loads at E0..E(N-1), drain at EN; `done` high after EN+1.
- len=0 or mode 3: `done` high after E0.

## Structure
- A shared package `dma_pkg` holds the mode encodings and state encodings, plus `AW`/`DW` defaults. The same widths are used by `ram` and the CPU.
- One natural sub-module, `dma_addr_gen`: latched base plus wrapping offset counter, with a last-word flag. It is instantiated for the source and destination sides.
- Everything else (FSM, accumulator, output registers) lives in `ram_dma`.

## Test plan
- Fill: dst=5, len=3, fill_data=0x0ABCD → RAM[5..7]=0x0ABCD, RAM[8] unchanged; `done` after E3.
- Copy: preload RAM[0..3]=101,202,303,404; src=0, dst=100, len=4 → RAM[100..103]=101..404; `done` after E8; no cycle with str=ld=1.
- Checksum with wrap: RAM[1022]=0xFFFFF, RAM[1023]=2, RAM[0]=3; src=1022, len=3 → `result`=0x00004; `done` after E4.
- len=0 and mode=3 → `done` after E0, no str/ld, `err`=1 only for mode 3.
- Start during busy → ignored. Deassert `rst_n` mid-copy after 2 words → all outputs 0 asynchronously, remaining destination words unchanged.
- Len=1024 fill from dst=512 → all 1024 words written, `busy` exactly 1025 cycles.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared encodings and default widths for the RAM DMA initiator.
package dma_pkg;

    // Same widths as the ram block and the CPU datapath.
    localparam int unsigned DefaultAw = 10;
    localparam int unsigned DefaultDw = 20;

    typedef enum logic [1:0] {
        ModeCopy = 2'd0,
        ModeFill = 2'd1,
        ModeSum  = 2'd2,
        ModeRsvd = 2'd3
    } dma_mode_e;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StCopyRd   = 3'd1,
        StCopyWr   = 3'd2,
        StFill     = 3'd3,
        StSumRd    = 3'd4,
        StSumDrain = 3'd5,
        StDone     = 3'd6
    } dma_state_e;

endpackage

// File: rtl/dma_addr_gen.sv
// Block address generator: latched base plus a wrapping offset.
// The offset counts words already issued, so addr_o is always the next word to issue
// and last_o says the whole block has been issued.
module dma_addr_gen
    import dma_pkg::*;
#(
    parameter int unsigned AW = DefaultAw
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [AW-1:0] base_i,
    input  logic [AW:0]   len_i,
    input  logic          step_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    logic [AW-1:0] base_q;
    logic [AW:0]   len_q;
    logic [AW:0]   off_q;

    // Latch the descriptor on load; a load with step means word 0 is issued that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            len_q  <= '0;
            off_q  <= '0;
        end else if (load_i) begin
            base_q <= base_i;
            len_q  <= len_i;
            off_q  <= step_i ? (AW+1)'(1) : '0;
        end else if (step_i) begin
            off_q <= off_q + (AW+1)'(1);
        end
    end

    // Address arithmetic wraps modulo 2^AW.
    assign addr_o = base_q + off_q[AW-1:0];
    assign last_o = (off_q == len_q);

endmodule

// File: rtl/ram_dma.sv
// Word-level RAM initiator: block copy, block fill and wrapping block checksum.
module ram_dma
    import dma_pkg::*;
#(
    parameter int unsigned AW = DefaultAw,
    parameter int unsigned DW = DefaultDw
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] fill_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] result,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_write,
    output logic          mem_str,
    output logic          mem_ld,
    input  logic [DW-1:0] mem_read
);

    dma_state_e    state_q, state_d;
    dma_mode_e     mode_in;
    logic          accept;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          str_q, str_d;
    logic          ld_q, ld_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          ld_prev_q;
    logic [DW-1:0] fill_q;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] result_q, result_d;

    logic          src_step, dst_step;
    logic [AW-1:0] src_next, dst_next;
    logic          src_last, dst_last;

    assign mode_in = dma_mode_e'(mode);
    assign accept  = (state_q == StIdle) && start;

    dma_addr_gen #(
        .AW (AW)
    ) u_src_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept),
        .base_i (src_addr),
        .len_i  (len),
        .step_i (src_step),
        .addr_o (src_next),
        .last_o (src_last)
    );

    dma_addr_gen #(
        .AW (AW)
    ) u_dst_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept),
        .base_i (dst_addr),
        .len_i  (len),
        .step_i (dst_step),
        .addr_o (dst_next),
        .last_o (dst_last)
    );

    // State, registered port outputs, descriptor and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            str_q     <= 1'b0;
            ld_q      <= 1'b0;
            addr_q    <= '0;
            ld_prev_q <= 1'b0;
            fill_q    <= '0;
            acc_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            str_q     <= str_d;
            ld_q      <= ld_d;
            addr_q    <= addr_d;
            ld_prev_q <= ld_q;
            acc_q     <= acc_d;
            result_q  <= result_d;
            if (accept) begin
                fill_q <= fill_data;
            end
        end
    end

    // Next state and next values of the registered outputs; each branch issues
    // the RAM access that the following cycle will present.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        str_d    = 1'b0;
        ld_d     = 1'b0;
        addr_d   = '0;
        acc_d    = acc_q;
        result_d = result_q;
        src_step = 1'b0;
        dst_step = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d = 1'b1;
                    acc_d  = '0;
                    if (len == '0 || mode_in == ModeRsvd) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        err_d   = (mode_in == ModeRsvd);
                        // An empty checksum is zero.
                        if (mode_in == ModeSum) begin
                            result_d = '0;
                        end
                    end else begin
                        unique case (mode_in)
                            ModeCopy: begin
                                state_d  = StCopyRd;
                                ld_d     = 1'b1;
                                addr_d   = src_addr;
                                src_step = 1'b1;
                            end
                            ModeFill: begin
                                state_d  = StFill;
                                str_d    = 1'b1;
                                addr_d   = dst_addr;
                                dst_step = 1'b1;
                            end
                            ModeSum: begin
                                state_d  = StSumRd;
                                ld_d     = 1'b1;
                                addr_d   = src_addr;
                                src_step = 1'b1;
                            end
                            default: begin
                                state_d = StIdle;
                            end
                        endcase
                    end
                end
            end

            StCopyRd: begin
                state_d  = StCopyWr;
                str_d    = 1'b1;
                addr_d   = dst_next;
                dst_step = 1'b1;
            end

            StCopyWr: begin
                if (src_last) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    state_d  = StCopyRd;
                    ld_d     = 1'b1;
                    addr_d   = src_next;
                    src_step = 1'b1;
                end
            end

            StFill: begin
                if (dst_last) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    str_d    = 1'b1;
                    addr_d   = dst_next;
                    dst_step = 1'b1;
                end
            end

            StSumRd: begin
                // Read data is valid only in the cycle after a load.
                if (ld_prev_q) begin
                    acc_d = acc_q + mem_read;
                end
                if (src_last) begin
                    state_d = StSumDrain;
                end else begin
                    ld_d     = 1'b1;
                    addr_d   = src_next;
                    src_step = 1'b1;
                end
            end

            StSumDrain: begin
                // Last load's data arrives here; fold it in and publish the sum.
                acc_d    = acc_q + mem_read;
                result_d = acc_q + mem_read;
                state_d  = StDone;
                done_d   = 1'b1;
            end

            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Write data is routed combinationally so a copy needs no holding register.
    always_comb begin
        mem_write = '0;
        unique case (state_q)
            StCopyWr: mem_write = mem_read;
            StFill:   mem_write = fill_q;
            default:  mem_write = '0;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign result   = result_q;
    assign mem_addr = addr_q;
    assign mem_str  = str_q;
    assign mem_ld   = ld_q;

endmodule

// File: tb/tb_ram_dma.sv
// Randomized self-checking bench for ram_dma with a behavioural RAM and block-level model.
module tb_ram_dma;

    localparam int Words = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [9:0]  src_addr;
    logic [9:0]  dst_addr;
    logic [10:0] len;
    logic [19:0] fill_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [19:0] result;
    logic [9:0]  mem_addr;
    logic [19:0] mem_write;
    logic        mem_str;
    logic        mem_ld;
    logic [19:0] mem_read;

    int n_tests = 0;
    int n_fail  = 0;

    logic [19:0] mem     [Words];
    logic [19:0] ref_mem [Words];
    logic [19:0] rd_q;
    logic        sync = 1'b0;
    logic [19:0] exp_result;

    always #5 clk = ~clk;

    ram_dma dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .fill_data (fill_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_str   (mem_str),
        .mem_ld    (mem_ld),
        .mem_read  (mem_read)
    );

    // Behavioural ram: synchronous store, load data visible the cycle after ld.
    assign mem_read = rd_q;
    always @(posedge clk) begin
        if (sync) begin
            for (int i = 0; i < Words; i++) mem[i] <= ref_mem[i];
        end else if (mem_str) begin
            mem[mem_addr] <= mem_write;
        end
        if (mem_ld) rd_q <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sync_mem();
        @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < Words; i++) if (mem[i] !== ref_mem[i]) bad++;
        check({tag, "_mem"}, bad, 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_str"}, mem_str, 0);
        check({tag, "_ld"}, mem_ld, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_write, 0);
        check({tag, "_result"}, result, 0);
    endtask

    // One descriptor through the DUT; the model updates ref_mem and the expected timing.
    task automatic run_op(input int m, input int src, input int dst, input int n,
                          input logic [19:0] fv, input bit poke, input string tag);
        int k_exp, str_exp, ld_exp, k;
        int busy_cnt, str_cnt, ld_cnt, both_cnt;
        logic err_exp, err_seen;
        logic [19:0] s;

        str_exp = 0;
        ld_exp  = 0;
        err_exp = (m == 3);
        if (n == 0 || m == 3) begin
            k_exp = 0;
            if (m == 2) exp_result = '0;
        end else if (m == 0) begin
            for (int i = 0; i < n; i++) ref_mem[(dst + i) % Words] = ref_mem[(src + i) % Words];
            k_exp = 2 * n; str_exp = n; ld_exp = n;
        end else if (m == 1) begin
            for (int i = 0; i < n; i++) ref_mem[(dst + i) % Words] = fv;
            k_exp = n; str_exp = n;
        end else begin
            s = '0;
            for (int i = 0; i < n; i++) s = s + ref_mem[(src + i) % Words];
            exp_result = s;
            k_exp = n + 1; ld_exp = n;
        end

        @(negedge clk);
        start     = 1'b1;
        mode      = 2'(m);
        src_addr  = 10'(src);
        dst_addr  = 10'(dst);
        len       = 11'(n);
        fill_data = fv;
        @(negedge clk);
        // The descriptor must have been latched; scramble the inputs.
        start     = 1'b0;
        mode      = 2'($urandom_range(0, 3));
        src_addr  = 10'($urandom);
        dst_addr  = 10'($urandom);
        len       = 11'($urandom_range(0, 1024));
        fill_data = 20'($urandom);

        k = -1; busy_cnt = 0; str_cnt = 0; ld_cnt = 0; both_cnt = 0; err_seen = 1'b0;
        for (int i = 0; i < 2 * Words + 16; i++) begin
            if (i > 0) @(negedge clk);
            if (poke && i == 1 && k_exp >= 2) begin
                start = 1'b1; mode = 2'd1; len = 11'd5;
            end
            if (i == 2) start = 1'b0;
            if (busy) busy_cnt++;
            if (mem_str) str_cnt++;
            if (mem_ld) ld_cnt++;
            if (mem_str && mem_ld) both_cnt++;
            if (done) begin
                k = i;
                err_seen = err;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, k, k_exp);
        check({tag, "_err"}, err_seen, err_exp);
        check({tag, "_str_count"}, str_cnt, str_exp);
        check({tag, "_ld_count"}, ld_cnt, ld_exp);
        check({tag, "_str_and_ld"}, both_cnt, 0);
        check({tag, "_busy_cycles"}, busy_cnt, k_exp + 1);
        @(negedge clk);
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_result"}, result, exp_result);
        check_mem(tag);
    endtask

    initial begin
        int m, n;
        rst_n = 1'b0; start = 1'b0; mode = '0; src_addr = '0; dst_addr = '0;
        len = '0; fill_data = '0; exp_result = '0;
        for (int i = 0; i < Words; i++) ref_mem[i] = 20'($urandom);
        #1;
        check_quiet("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sync_mem();
        check_mem("preload");

        // Directed cases.
        run_op(1, 0, 5, 3, 20'h0ABCD, 1'b0, "fill3");
        check("fill3_word8_kept", mem[8], ref_mem[8]);
        check("fill3_word7", mem[7], 20'h0ABCD);
        ref_mem[0] = 20'd101; ref_mem[1] = 20'd202; ref_mem[2] = 20'd303; ref_mem[3] = 20'd404;
        sync_mem();
        run_op(0, 0, 100, 4, 20'h0, 1'b0, "copy4");
        check("copy4_word103", mem[103], 20'd404);
        ref_mem[1022] = 20'hFFFFF; ref_mem[1023] = 20'd2; ref_mem[0] = 20'd3;
        sync_mem();
        run_op(2, 1022, 0, 3, 20'h0, 1'b0, "sum_wrap");
        check("sum_wrap_value", result, 20'h00004);
        run_op(0, 10, 20, 0, 20'h0, 1'b0, "len0");
        run_op(3, 10, 20, 5, 20'h12345, 1'b0, "mode3");
        run_op(0, 30, 32, 9, 20'h0, 1'b1, "copy_overlap_poke");
        run_op(1, 512, 0, 1024, 20'h5A5A5, 1'b1, "fill1024");

        // Reset in the middle of a copy, after two words have been stored.
        for (int i = 0; i < 2; i++) ref_mem[300 + i] = ref_mem[200 + i];
        @(negedge clk);
        start = 1'b1; mode = 2'd0; src_addr = 10'd200; dst_addr = 10'd300; len = 11'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_result = '0;
        check_quiet("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_mem("mid_reset");

        // Randomized descriptors.
        for (int t = 0; t < 30; t++) begin
            m = $urandom_range(0, 3);
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1024) : $urandom_range(0, 24);
            run_op(m, $urandom_range(0, 1023), $urandom_range(0, 1023), n, 20'($urandom),
                   1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
